// File: rtl/stepper_phase_decoder.sv
// -----------------------------------------------------------------------------
// stepper_phase_decoder
//
// Recovers the half-step state of a stepper motor by watching its four coil
// drive lines. Each line is synchronised, its PWM stripped by a retriggerable
// envelope detector, and the resulting 4-bit coil pattern is debounced before
// being decoded to a half-step index. A two-state tracker (IDLE / TRACK) turns
// successive indices into a signed position, a direction bit and a step
// strobe, and raises a sticky fault on illegal patterns or skipped steps.
//
// Optional feature (macro STEP_PERIOD_EN): measures the clock-cycle interval
// between counted steps on step_period. Without the macro, step_period is 0.
//
// Parameters:
//   PWM_WIN    envelope hold window in CLK cycles (must exceed PWM period)
//   STABLE_CYC cycles a pattern must hold before it is accepted
//   POS_W      position counter width
//
// Ports:
//   CLK          system clock (only clock)
//   RST          synchronous active-high reset
//   INA, INA2,
//   INB, INB2    coil drive lines, PWM-modulated, asynchronous to CLK
//   clr_fault    one-cycle pulse clearing fault (a simultaneous set wins)
//   pos          signed half-step position, wraps modulo 2^POS_W
//   dir          direction of last counted step (1 = forward)
//   step_pulse   one-cycle strobe per counted step
//   phase_idx    last accepted half-step index
//   idle         accepted pattern is all coils off
//   fault        sticky error flag
//   step_period  cycles between the last two counted steps (optional feature)
// -----------------------------------------------------------------------------
module stepper_phase_decoder #(
  parameter int PWM_WIN    = 300,
  parameter int STABLE_CYC = 512,
  parameter int POS_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INA,
  input  logic             INA2,
  input  logic             INB,
  input  logic             INB2,
  input  logic             clr_fault,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             step_pulse,
  output logic [2:0]       phase_idx,
  output logic             idle,
  output logic             fault,
  output logic [23:0]      step_period
);

  localparam int ENV_W  = $clog2(PWM_WIN + 1);
  localparam int STAB_W = $clog2(STABLE_CYC + 1);
  localparam logic [ENV_W-1:0]  ENV_RELOAD = ENV_W'(PWM_WIN);
  localparam logic [STAB_W-1:0] STAB_FULL  = STAB_W'(STABLE_CYC);
  localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(STABLE_CYC - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Bit order of the pattern is {A, A2, B, B2}.
  logic [3:0] coil_raw;
  logic [3:0] coil_on;

  assign coil_raw = {INA, INA2, INB, INB2};

  // ---------------------------------------------------------------------------
  // Per-coil synchroniser and envelope detector. A high sample reloads the
  // hold counter, so the coil reads "on" through the PWM off-time.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_coil
      logic             sync1_reg;
      logic             sync2_reg;
      logic [ENV_W-1:0] env_cnt_reg;

      always_ff @(posedge CLK) begin
        if (RST) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          env_cnt_reg <= '0;
        end else begin
          sync1_reg <= coil_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg) begin
            env_cnt_reg <= ENV_RELOAD;
          end else if (env_cnt_reg != '0) begin
            env_cnt_reg <= env_cnt_reg - 1'b1;
          end
        end
      end

      assign coil_on[gi] = (env_cnt_reg != '0);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stability filter. The counter parks at STABLE_CYC so a held pattern is
  // accepted exactly once; any candidate change restarts it.
  // ---------------------------------------------------------------------------
  logic [3:0]        cand_reg;
  logic [STAB_W-1:0] stab_cnt_reg;
  logic              accept_now;

  assign accept_now = (coil_on == cand_reg) && (stab_cnt_reg == STAB_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cand_reg     <= 4'b0000;
      stab_cnt_reg <= '0;
    end else if (coil_on != cand_reg) begin
      cand_reg     <= coil_on;
      stab_cnt_reg <= '0;
    end else if (stab_cnt_reg != STAB_FULL) begin
      stab_cnt_reg <= stab_cnt_reg + 1'b1;
    end
  end

  // Decode register: the accepted pattern, valid for one cycle.
  logic       acc_valid_reg;
  logic [3:0] acc_pat_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_valid_reg <= 1'b0;
      acc_pat_reg   <= 4'b0000;
    end else begin
      acc_valid_reg <= accept_now;
      acc_pat_reg   <= cand_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern to half-step index.
  // ---------------------------------------------------------------------------
  logic [2:0] dec_idx;
  logic       dec_legal;
  logic       dec_zero;

  always_comb begin
    dec_idx   = 3'd0;
    dec_legal = 1'b1;
    dec_zero  = 1'b0;
    case (acc_pat_reg)
      4'b0001: dec_idx = 3'd0;
      4'b0101: dec_idx = 3'd1;
      4'b0100: dec_idx = 3'd2;
      4'b0110: dec_idx = 3'd3;
      4'b0010: dec_idx = 3'd4;
      4'b1010: dec_idx = 3'd5;
      4'b1000: dec_idx = 3'd6;
      4'b1001: dec_idx = 3'd7;
      4'b0000: begin
        dec_legal = 1'b0;
        dec_zero  = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Tracker FSM.
  // ---------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [POS_W-1:0] pos_reg, pos_next;
  logic             dir_reg, dir_next;
  logic             step_reg, step_next;
  logic [2:0]       idx_reg, idx_next;
  logic             idle_reg, idle_next;
  logic             fault_reg, fault_next;
  logic             fault_set;
  logic [2:0]       idx_diff;

  // Modulo-8 distance: 1 is a forward step, 7 a reverse step, 2..6 a skip.
  assign idx_diff = dec_idx - idx_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      pos_reg   <= '0;
      dir_reg   <= 1'b0;
      step_reg  <= 1'b0;
      idx_reg   <= 3'd0;
      idle_reg  <= 1'b1;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      dir_reg   <= dir_next;
      step_reg  <= step_next;
      idx_reg   <= idx_next;
      idle_reg  <= idle_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    dir_next   = dir_reg;
    step_next  = 1'b0;
    idx_next   = idx_reg;
    idle_next  = idle_reg;
    fault_set  = 1'b0;

    if (acc_valid_reg) begin
      if (dec_zero) begin
        if (state_reg == ST_TRACK) begin
          state_next = ST_IDLE;
          idle_next  = 1'b1;
        end
      end else if (!dec_legal) begin
        fault_set = 1'b1;
      end else if (state_reg == ST_IDLE) begin
        // Entry only establishes the reference index; it never counts.
        state_next = ST_TRACK;
        idx_next   = dec_idx;
        idle_next  = 1'b0;
      end else if (idx_diff == 3'd1) begin
        pos_next  = pos_reg + 1'b1;
        dir_next  = 1'b1;
        idx_next  = dec_idx;
        step_next = 1'b1;
      end else if (idx_diff == 3'd7) begin
        pos_next  = pos_reg - 1'b1;
        dir_next  = 1'b0;
        idx_next  = dec_idx;
        step_next = 1'b1;
      end else if (idx_diff != 3'd0) begin
        // Skip: position is unknowable, so flag and resync the index.
        fault_set = 1'b1;
        idx_next  = dec_idx;
      end
    end

    // Set takes priority over a coincident clear.
    fault_next = fault_set | (fault_reg & ~clr_fault);
  end

  assign pos        = pos_reg;
  assign dir        = dir_reg;
  assign step_pulse = step_reg;
  assign phase_idx  = idx_reg;
  assign idle       = idle_reg;
  assign fault      = fault_reg;

  // ---------------------------------------------------------------------------
  // Optional step-interval measurement.
  // ---------------------------------------------------------------------------
`ifdef STEP_PERIOD_EN
  logic [23:0] period_cnt_reg;
  logic [23:0] step_period_reg;
  logic        idle_entry;
  logic        skip_fault;

  assign idle_entry = acc_valid_reg && dec_zero && (state_reg == ST_TRACK);
  assign skip_fault = acc_valid_reg && dec_legal && (state_reg == ST_TRACK) &&
                      (idx_diff != 3'd0) && (idx_diff != 3'd1) && (idx_diff != 3'd7);

  always_ff @(posedge CLK) begin
    if (RST) begin
      period_cnt_reg  <= 24'd0;
      step_period_reg <= 24'd0;
    end else if (step_next) begin
      // +1 counts the step cycle itself so the latched value is the full
      // edge-to-edge interval.
      step_period_reg <= (period_cnt_reg == 24'hFFFFFF) ? 24'hFFFFFF
                                                        : period_cnt_reg + 24'd1;
      period_cnt_reg  <= 24'd0;
    end else if (idle_entry || skip_fault) begin
      period_cnt_reg <= 24'd0;
    end else if (period_cnt_reg != 24'hFFFFFF) begin
      period_cnt_reg <= period_cnt_reg + 24'd1;
    end
  end

  assign step_period = step_period_reg;
`else
  assign step_period = 24'd0;
`endif

endmodule

// File: doc/stepper_phase_decoder.md
# stepper_phase_decoder

Monitors the four stepper coil drive lines (INA, INA2, INB, INB2) and recovers the motor's half-step state from them. It strips the per-coil PWM, debounces the resulting 4-bit coil pattern and decodes it into a half-step index. From successive indices it tracks signed position and direction, and flags illegal patterns and skipped steps. It sits alongside the motor driver, on the pins or on loop-back, as the closed-loop position and fault monitor.

## Interface
- `PWM_WIN`, 300: hold window in CLK cycles for the per-coil envelope detector. Must exceed the 256-cycle PWM period.
- `STABLE_CYC`, 512: cycles a decoded pattern must stay unchanged before it is accepted.
- `POS_W`, 16: position counter width.
- `CLK` input 1: system clock, 50 MHz. This is the only clock.
- `RST` input 1: synchronous, active-high reset.
- `INA`, `INA2`, `INB`, `INB2` input 1 each: coil drive lines, PWM-modulated, asynchronous to CLK.
- `clr_fault` input 1: one-cycle pulse that clears `fault`.
- `pos` output POS_W: signed two's-complement half-step position.
- `dir` output 1: direction of the last counted step. 1 = forward (index +1), 0 = reverse.
- `step_pulse` output 1: one-cycle strobe on each counted step.
- `phase_idx` output 3: last accepted half-step index.
- `idle` output 1: accepted pattern is 0000 (all coils off).
- `fault` output 1: sticky error flag.
- `step_period` output 24: see Configuration.

## Operation
- **Synchronizer:** two-flop synchronizer on each coil line.
- **Envelope detector:** one counter per coil.
  - A high sample reloads the counter to PWM_WIN.
  - Otherwise the counter decrements, saturating at 0.
  - `coil_on` = counter ≠ 0.
- **Stability filter:** candidate pattern is {A, A2, B, B2}, bits [3:0].
  - Any change of the candidate restarts the stability counter.
  - When the counter reaches STABLE_CYC, the pattern is accepted once.
  - A stable pattern is not re-accepted.
- **Decode table:** 0001→0, 0101→1, 0100→2, 0110→3, 0010→4, 1010→5, 1000→6, 1001→7.
  - 0000 decodes to idle.
  - The other 7 patterns are illegal.
- **State machine:** states IDLE and TRACK.
  - IDLE + legal pattern → TRACK. `phase_idx` is loaded; no count; `idle` = 0.
  - TRACK + pattern 0000 → IDLE. `idle` = 1; `pos` and `phase_idx` are held.
  - TRACK + new index = `phase_idx`+1 mod 8 → `pos` +1, `dir` = 1, `step_pulse`.
  - TRACK + new index = `phase_idx`−1 mod 8 → `pos` −1, `dir` = 0, `step_pulse`.
  - TRACK + jump of ±2..4 (skip) → `fault` set, `pos` unchanged, `phase_idx` resynced to the new index.
  - Either state + illegal pattern → `fault` set. State, `pos` and `phase_idx` are unchanged.
- **Wrap rules:**
  - Index arithmetic is modulo 8: 7→0 is forward, 0→7 is reverse.
  - `pos` wraps modulo 2^POS_W with no saturation.
- **Fault flag:**
  - `fault` stays set until `clr_fault` or `RST`.
  - If a set event and `clr_fault` occur in the same cycle, set wins.

## Timing
- **Latency:** coil edge to acceptance is 2 (sync) + 1 (envelope) + STABLE_CYC + 1 (decode register) cycles.
  - Added coil: 516 cycles with defaults.
  - Removed coil: add PWM_WIN envelope decay, 816 cycles with defaults.
- **Outputs:** `step_pulse`, `pos`, `dir`, `phase_idx`, `idle` and `fault` all update in the same registered cycle.
- **Reset values:** `pos` = 0, `dir` = 0, `step_pulse` = 0, `phase_idx` = 0, `idle` = 1, `fault` = 0, `step_period` = 0, state = IDLE. Envelope and stability counters = 0.
- **Reset mid-operation:** everything clears in the cycle after `RST` is sampled high. The first accepted legal pattern after reset is an IDLE→TRACK entry and does not count.
- **Minimum step spacing:** STABLE_CYC + 4 cycles. Faster changes are filtered as glitches.

## Configuration
- `STEP_PERIOD_EN` defined:
  - A 24-bit cycle counter runs between counted steps and saturates at 0xFFFFFF.
  - On each `step_pulse` its value is latched into `step_period` and the counter restarts.
  - The counter resets, without latching, on IDLE entry and on skip faults.
- `STEP_PERIOD_EN` undefined: `step_period` is tied to 0 and no counter logic is built.

## Test plan
- **Reset:** hold `RST` 5 cycles with coils low → `idle` = 1, `pos` = 0, `fault` = 0, no `step_pulse`.
- **Forward revolution:** drive 0001, then 0101, 0100, 0110, 0010, 1010, 1000, 1001, 0001 with 180/256 PWM and 20000-cycle steps. Required response:
  - 8 `step_pulse` strobes, `pos` = 8, `dir` = 1, `phase_idx` = 0.
  - With `STEP_PERIOD_EN`, `step_period` = 20000 ±2.
- **Reverse from reset:** 0001, 1001, 1000, 1010 → `pos` = −3 (0xFFFD), `dir` = 0, `phase_idx` = 5.
- **Illegal pattern:** hold 1100 for 2000 cycles while in TRACK at index 2 → `fault` = 1, `pos` and `phase_idx` unchanged.
  - Then pulse `clr_fault` → `fault` = 0.
  - `clr_fault` in the same cycle as a new fault → `fault` = 1.
- **Skip:** 0001 → 0100 → `fault` = 1, `pos` unchanged, `phase_idx` = 2.
  - Next 0110 → `pos` +1.
- **Glitch and idle:** a 100-cycle 0101 glitch inside a stable 0001 produces no step. Coils to 0000 → `idle` = 1 after PWM_WIN + STABLE_CYC + 4 cycles, with `pos` held.
